// File: rtl/wb_pkg.sv
// Shared types and constants for the integer register-file writeback stage.
package wb_pkg;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // x0 is hardwired to zero, so a write to it is never committed.
  function automatic logic rd_writes(input logic [REG_AW-1:0] rd);
    return rd != '0;
  endfunction
endpackage

// File: rtl/regfile_wb_if.sv
// Writeback stage bus: ALU result, long-latency handshake, issue tracking and register-file write port.
interface regfile_wb_if;
  import wb_pkg::*;

  logic                alu_valid;
  logic [REG_AW-1:0]   alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                ll_valid;
  logic                ll_ready;
  logic [REG_AW-1:0]   ll_rd;
  logic [XLEN-1:0]     ll_data;
  logic                issue_valid;
  logic [REG_AW-1:0]   issue_rd;
  logic [NUM_REGS-1:0] busy;
  logic                wen;
  logic [REG_AW-1:0]   waddr;
  logic [XLEN-1:0]     wdata;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ll_valid, ll_rd, ll_data,
    output issue_valid, issue_rd,
    input  ll_ready, busy, wen, waddr, wdata
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ll_valid, ll_rd, ll_data,
    input  issue_valid, issue_rd,
    output ll_ready, busy, wen, waddr, wdata
  );
endinterface

// File: rtl/wb_fifo.sv
// Long-latency result FIFO; pointers carry one extra MSB to tell full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  wb_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// Writeback arbiter: ALU beats long-latency FIFO for the single register-file write port; keeps the busy scoreboard.
// Optional WB_LL_BYPASS_EN: a long-latency result arriving to an idle stage skips the FIFO.
module regfile_wb
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave wb
);
  wb_entry_t           head;
  wb_entry_t           ll_entry;
  wb_entry_t           sel_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                ll_accept;
  logic                bypass;
  logic                sel_valid;
  logic                sel_ll;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wen_q;
  logic [REG_AW-1:0]   waddr_q;
  logic [XLEN-1:0]     wdata_q;

  assign ll_entry  = '{rd: wb.ll_rd, data: wb.ll_data};
  assign ll_accept = wb.ll_valid && !fifo_full;

`ifdef WB_LL_BYPASS_EN
  assign bypass = fifo_empty && !wb.alu_valid && wb.ll_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = ll_accept && !bypass;
  assign fifo_pop  = !wb.alu_valid && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (ll_entry),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_ll    = 1'b0;
    sel_entry = '0;
    if (wb.alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: wb.alu_rd, data: wb.alu_data};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_ll    = 1'b1;
      sel_entry = head;
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_ll    = 1'b1;
      sel_entry = ll_entry;
    end
  end

  // Clear before set so an issue to the same rd on the retiring edge keeps it busy.
  always_comb begin
    busy_nxt = busy_q;
    if (sel_ll && rd_writes(sel_entry.rd)) busy_nxt[sel_entry.rd] = 1'b0;
    if (wb.issue_valid && rd_writes(wb.issue_rd)) busy_nxt[wb.issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (sel_valid) begin
        wen_q   <= rd_writes(sel_entry.rd);
        waddr_q <= sel_entry.rd;
        wdata_q <= sel_entry.data;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

  assign wb.ll_ready = !fifo_full;
  assign wb.busy     = busy_q;
  assign wb.wen      = wen_q;
  assign wb.waddr    = waddr_q;
  assign wb.wdata    = wdata_q;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: every committed write is matched against a queue of expected {rd, data}.
module tb_regfile_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [68:0] exp_q[$];

  regfile_wb_if wb();

  regfile_wb #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data);
    exp_q.push_back({rd, data});
  endtask

  always @(negedge clk) begin
    logic [68:0] e;
    if (!rst && wb.wen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", wb.waddr, wb.wdata);
      end else begin
        e = exp_q.pop_front();
        assert ({wb.waddr, wb.wdata} === e) else begin
          errors++;
          $error("FAIL write_order observed=%0h_%0h expected=%0h_%0h", wb.waddr, wb.wdata, e[68:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    wb.alu_valid = 0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.ll_valid = 0; wb.ll_rd = '0; wb.ll_data = '0;
    wb.issue_valid = 0; wb.issue_rd = '0;

    // reset state
    step(); step();
    chk("rst_wen", 64'(wb.wen), 64'd0);
    chk("rst_waddr", 64'(wb.waddr), 64'd0);
    chk("rst_wdata", wb.wdata, 64'd0);
    chk("rst_busy", 64'(wb.busy), 64'd0);
    chk("rst_ll_ready", 64'(wb.ll_ready), 64'd1);
    rst = 0;
    step();

    // ALU only
    wb.alu_valid = 1; wb.alu_rd = 5'd3; wb.alu_data = 64'hDEAD_BEEF;
    expect_wr(5'd3, 64'hDEAD_BEEF);
    step();
    wb.alu_valid = 0;
    chk("alu_wen", 64'(wb.wen), 64'd1);
    chk("alu_waddr", 64'(wb.waddr), 64'd3);
    chk("alu_wdata", wb.wdata, 64'hDEAD_BEEF);
    wb.alu_valid = 1; wb.alu_rd = 5'd0; wb.alu_data = 64'h1234;
    step();
    wb.alu_valid = 0;
    chk("alu_x0_wen", 64'(wb.wen), 64'd0);
    step();

    // contention: ALU holds the port for 3 cycles, queued ll result rd=7 follows
    wb.issue_valid = 1; wb.issue_rd = 5'd7;
    step();
    wb.issue_valid = 0;
    chk("busy7_set", 64'(wb.busy[7]), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      wb.alu_valid = 1; wb.alu_rd = 5'(i); wb.alu_data = 64'(i * 16);
      expect_wr(5'(i), 64'(i * 16));
      wb.ll_valid = (i == 1); wb.ll_rd = 5'd7; wb.ll_data = 64'h11;
      step();
    end
    wb.alu_valid = 0; wb.ll_valid = 0;
    expect_wr(5'd7, 64'h11);
    chk("busy7_held", 64'(wb.busy[7]), 64'd1);
    step();
    chk("ll7_wen", 64'(wb.wen), 64'd1);
    chk("ll7_waddr", 64'(wb.waddr), 64'd7);
    chk("busy7_clear", 64'(wb.busy[7]), 64'd0);
    step();

    // full / back-pressure under ALU starvation
    for (int i = 0; i < 6; i++) begin
      wb.alu_valid = 1; wb.alu_rd = 5'(10 + i); wb.alu_data = 64'(32'h100 + i);
      expect_wr(5'(10 + i), 64'(32'h100 + i));
      if (i < 4) begin
        chk("ll_ready_free", 64'(wb.ll_ready), 64'd1);
        wb.ll_valid = 1; wb.ll_rd = 5'(20 + i); wb.ll_data = 64'(32'h200 + i);
      end else if (i == 4) begin
        chk("ll_ready_full", 64'(wb.ll_ready), 64'd0);
        wb.ll_valid = 1; wb.ll_rd = 5'd31; wb.ll_data = 64'hBAD;
      end else begin
        wb.ll_valid = 0;
      end
      step();
    end
    wb.alu_valid = 0; wb.ll_valid = 0;
    for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 64'(32'h200 + i));
    step();
    chk("ll_ready_after_pop", 64'(wb.ll_ready), 64'd1);
    repeat (4) step();

    // scoreboard race: re-issue of rd=9 on the edge its old result retires
    wb.issue_valid = 1; wb.issue_rd = 5'd9;
    step();
    wb.issue_valid = 0;
    wb.alu_valid = 1; wb.alu_rd = 5'd1; wb.alu_data = 64'h55;
    wb.ll_valid = 1; wb.ll_rd = 5'd9; wb.ll_data = 64'h99;
    expect_wr(5'd1, 64'h55);
    step();
    wb.alu_valid = 0; wb.ll_valid = 0;
    wb.issue_valid = 1; wb.issue_rd = 5'd9;
    expect_wr(5'd9, 64'h99);
    step();
    wb.issue_valid = 0;
    chk("race_wen9", 64'(wb.waddr), 64'd9);
    chk("race_busy9", 64'(wb.busy[9]), 64'd1);
    step();
    chk("race_busy9_hold", 64'(wb.busy[9]), 64'd1);

    // long-latency entry for x0 is popped without a write
    wb.alu_valid = 1; wb.alu_rd = 5'd2; wb.alu_data = 64'h22;
    wb.ll_valid = 1; wb.ll_rd = 5'd0; wb.ll_data = 64'h77;
    expect_wr(5'd2, 64'h22);
    step();
    wb.alu_valid = 0; wb.ll_valid = 0;
    step();
    chk("ll_x0_wen", 64'(wb.wen), 64'd0);
    step();

    // bypass latency
    wb.ll_valid = 1; wb.ll_rd = 5'd4; wb.ll_data = 64'h42;
    expect_wr(5'd4, 64'h42);
    step();
    wb.ll_valid = 0;
`ifdef WB_LL_BYPASS_EN
    chk("byp_wen_1cyc", 64'(wb.wen), 64'd1);
    chk("byp_waddr", 64'(wb.waddr), 64'd4);
    step();
`else
    chk("nobyp_wen_1cyc", 64'(wb.wen), 64'd0);
    step();
    chk("nobyp_wen_2cyc", 64'(wb.wen), 64'd1);
    chk("nobyp_waddr", 64'(wb.waddr), 64'd4);
`endif
    step();

    // reset mid-stream with two entries queued and busy[5] set
    wb.issue_valid = 1; wb.issue_rd = 5'd5;
    step();
    wb.issue_valid = 0;
    chk("busy5_set", 64'(wb.busy[5]), 64'd1);
    wb.alu_valid = 1; wb.alu_rd = 5'd1; wb.alu_data = 64'h31;
    wb.ll_valid = 1; wb.ll_rd = 5'd6; wb.ll_data = 64'h66;
    expect_wr(5'd1, 64'h31);
    step();
    wb.alu_rd = 5'd2; wb.alu_data = 64'h32;
    wb.ll_rd = 5'd7; wb.ll_data = 64'h67;
    step();
    rst = 1; wb.alu_valid = 0; wb.ll_valid = 0;
    #1;
    chk("mid_rst_wen", 64'(wb.wen), 64'd0);
    chk("mid_rst_busy", 64'(wb.busy), 64'd0);
    chk("mid_rst_ll_ready", 64'(wb.ll_ready), 64'd1);
    step(); step();
    rst = 0;
    repeat (4) step();
    chk("post_rst_wen", 64'(wb.wen), 64'd0);
    chk("post_rst_busy", 64'(wb.busy), 64'd0);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
